// File: rtl/opl3_timer_bank.sv
// ---------------------------------------------------------------------------
// opl3_timer_bank
//
// Bank of OPL3-style interval timers. A shared base prescaler produces a
// base tick every BASE_TICK_CYCLES clocks. Timer 0 advances on every base
// tick. Timer i (i > 0) advances once every 2^(i*PRESCALE_LOG2) base ticks.
// Each timer counts up from its preset. When it passes all-ones it reloads
// the preset and reports an overflow. That overflow produces a one-cycle
// pulse and, unless masked, sets a sticky flag that feeds irq.
//
// Ports
//   clk           single clock
//   reset_n       asynchronous active-low reset
//   preset_wr     one-cycle preset write strobe
//   preset_sel    target timer of a preset write (out-of-range is ignored)
//   preset_val    preset value to write
//   ctrl_wr       one-cycle control write strobe
//   ctrl_irq_rst  with ctrl_wr: clear all flags; mask/start are not written
//   ctrl_mask     per-timer flag mask; writing a 1 also clears that flag
//   ctrl_start    per-timer run enable; a 0->1 edge loads the preset
//   ovf_pulse     per-timer overflow pulse, one cycle after the wrapping tick
//   flags         sticky per-timer overflow flags
//   irq           OR of all flags (combinational)
// ---------------------------------------------------------------------------
module opl3_timer_bank #(
  parameter int NUM_TIMERS       = 2,
  parameter int TIMER_WIDTH      = 8,
  parameter int BASE_TICK_CYCLES = 1018,
  parameter int PRESCALE_LOG2    = 2,
  localparam int SEL_W  = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1,
  localparam int BASE_W = (BASE_TICK_CYCLES > 1) ? $clog2(BASE_TICK_CYCLES) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   preset_wr,
  input  logic [SEL_W-1:0]       preset_sel,
  input  logic [TIMER_WIDTH-1:0] preset_val,
  input  logic                   ctrl_wr,
  input  logic                   ctrl_irq_rst,
  input  logic [NUM_TIMERS-1:0]  ctrl_mask,
  input  logic [NUM_TIMERS-1:0]  ctrl_start,
  output logic [NUM_TIMERS-1:0]  ovf_pulse,
  output logic [NUM_TIMERS-1:0]  flags,
  output logic                   irq
);

  localparam logic [BASE_W-1:0]      BASE_LAST = BASE_W'(BASE_TICK_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] CNT_MAX   = '1;

  logic [BASE_W-1:0]      base_cnt;
  logic                   base_tick;
  logic [NUM_TIMERS-1:0]  tick;

  logic [NUM_TIMERS-1:0]  mask_r;
  logic [NUM_TIMERS-1:0]  start_r;
  logic [TIMER_WIDTH-1:0] preset_q  [NUM_TIMERS];
  logic [TIMER_WIDTH-1:0] counter_q [NUM_TIMERS];

  logic                   ctrl_load;
  logic [NUM_TIMERS-1:0]  start_rise;
  logic [NUM_TIMERS-1:0]  flag_clr;
  logic [NUM_TIMERS-1:0]  preset_hit;
  logic [NUM_TIMERS-1:0]  wrap_p0;

  // -------------------------------------------------------------------------
  // Base prescaler: free-runs 0..BASE_TICK_CYCLES-1 and is never reset by
  // start/stop, so the tick phase stays tied to reset release.
  // -------------------------------------------------------------------------
  assign base_tick = (base_cnt == BASE_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_cnt <= '0;
    end else if (base_tick) begin
      base_cnt <= '0;
    end else begin
      base_cnt <= base_cnt + BASE_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Per-timer sub-prescalers. Timer i ticks on the base tick where its
  // i*PRESCALE_LOG2-bit sub-prescaler is all-ones. Timer 0, or a zero
  // prescale shift, uses the base tick directly.
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_sub
    if (g == 0 || PRESCALE_LOG2 == 0) begin : g_direct
      assign tick[g] = base_tick;
    end else begin : g_div
      localparam int SUB_W = g * PRESCALE_LOG2;
      logic [SUB_W-1:0] sub_cnt;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sub_cnt <= '0;
        end else if (base_tick) begin
          sub_cnt <= sub_cnt + SUB_W'(1);
        end
      end

      assign tick[g] = base_tick & (&sub_cnt);
    end
  end

  // -------------------------------------------------------------------------
  // Write decode. An irq_rst write only clears flags. A normal control write
  // registers mask/start, and its mask 1-bits clear the matching flags.
  // -------------------------------------------------------------------------
  assign ctrl_load  = ctrl_wr & ~ctrl_irq_rst;
  assign start_rise = ctrl_load ? (ctrl_start & ~start_r) : '0;

  always_comb begin
    flag_clr = '0;
    if (ctrl_wr) begin
      flag_clr = ctrl_irq_rst ? {NUM_TIMERS{1'b1}} : ctrl_mask;
    end
  end

  always_comb begin
    preset_hit = '0;
    wrap_p0    = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      preset_hit[i] = preset_wr && (preset_sel == SEL_W'(i));
      wrap_p0[i]    = start_r[i] && tick[i] && (counter_q[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_r  <= '0;
      start_r <= '0;
    end else if (ctrl_load) begin
      mask_r  <= ctrl_mask;
      start_r <= ctrl_start;
    end
  end

  // -------------------------------------------------------------------------
  // Presets and counters. A start edge has priority over a coincident tick.
  // A preset written in the same cycle as the start edge is loaded directly.
  // Reloads on wrap use the preset register as it stood before this cycle's
  // write, so a write while running takes effect at the following reload.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        preset_q[i]  <= '0;
        counter_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (preset_hit[i]) begin
          preset_q[i] <= preset_val;
        end

        if (start_rise[i]) begin
          counter_q[i] <= preset_hit[i] ? preset_val : preset_q[i];
        end else if (start_r[i] && tick[i]) begin
          counter_q[i] <= wrap_p0[i] ? preset_q[i]
                                     : counter_q[i] + TIMER_WIDTH'(1);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Overflow outputs, one cycle after the wrapping tick. The pulse ignores
  // the mask. A flag is set only when unmasked, and a coincident clear wins.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_pulse <= '0;
      flags     <= '0;
    end else begin
      ovf_pulse <= wrap_p0;
      flags     <= (flags | (wrap_p0 & ~mask_r)) & ~flag_clr;
    end
  end

  assign irq = |flags;

endmodule

// File: tb/tb_opl3_timer_bank.sv
// ---------------------------------------------------------------------------
// tb_opl3_timer_bank
//
// Bench for opl3_timer_bank with BASE_TICK_CYCLES=4, PRESCALE_LOG2=2,
// NUM_TIMERS=2 and TIMER_WIDTH=8. cyc counts rising edges since the last
// reset release. With this numbering, timer 0 state changes on edges where
// cyc is a multiple of 4, and timer 1 state changes on edges where cyc is a
// multiple of 16. When stimulus is driven, the cycle of every expected
// overflow pulse is pushed into a per-timer queue. A monitor pops and
// compares each pulse against those queues.
// ---------------------------------------------------------------------------
module tb_opl3_timer_bank;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       preset_wr;
  logic [0:0] preset_sel;
  logic [7:0] preset_val;
  logic       ctrl_wr;
  logic       ctrl_irq_rst;
  logic [1:0] ctrl_mask;
  logic [1:0] ctrl_start;
  logic [1:0] ovf_pulse;
  logic [1:0] flags;
  logic       irq;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int exp_q0[$];
  int exp_q1[$];

  opl3_timer_bank #(
    .NUM_TIMERS      (2),
    .TIMER_WIDTH     (8),
    .BASE_TICK_CYCLES(4),
    .PRESCALE_LOG2   (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .preset_wr   (preset_wr),
    .preset_sel  (preset_sel),
    .preset_val  (preset_val),
    .ctrl_wr     (ctrl_wr),
    .ctrl_irq_rst(ctrl_irq_rst),
    .ctrl_mask   (ctrl_mask),
    .ctrl_start  (ctrl_start),
    .ovf_pulse   (ovf_pulse),
    .flags       (flags),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Returns at the falling edge that follows rising edge number c.
  task automatic goto(input int c);
    int guard = 0;
    while (cyc < c && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != c) chk("goto_bound", cyc, c);
  endtask

  // Drives a write that the DUT captures on rising edge c.
  task automatic preset_at(input int c, input logic sel, input logic [7:0] v);
    goto(c - 1);
    preset_wr  = 1'b1;
    preset_sel = sel;
    preset_val = v;
    @(negedge clk);
    preset_wr  = 1'b0;
  endtask

  task automatic ctrl_at(input int c, input logic rst, input logic [1:0] m, input logic [1:0] s);
    goto(c - 1);
    ctrl_wr      = 1'b1;
    ctrl_irq_rst = rst;
    ctrl_mask    = m;
    ctrl_start   = s;
    @(negedge clk);
    ctrl_wr      = 1'b0;
  endtask

  // Scoreboard monitor: every pulse must match the head of its queue.
  always @(negedge clk) begin
    if (reset_n) begin
      logic e0, e1;
      e0 = (exp_q0.size() > 0) && (exp_q0[0] == cyc);
      e1 = (exp_q1.size() > 0) && (exp_q1[0] == cyc);
      if (ovf_pulse[0] || e0) begin
        chk("ovf0", {31'd0, ovf_pulse[0]}, {31'd0, e0});
        if (e0) void'(exp_q0.pop_front());
      end
      if (ovf_pulse[1] || e1) begin
        chk("ovf1", {31'd0, ovf_pulse[1]}, {31'd0, e1});
        if (e1) void'(exp_q1.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    reset_n      = 1'b0;
    preset_wr    = 1'b0;
    preset_sel   = 1'b0;
    preset_val   = 8'h00;
    ctrl_wr      = 1'b0;
    ctrl_irq_rst = 1'b0;
    ctrl_mask    = 2'b00;
    ctrl_start   = 2'b00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ovf", ovf_pulse, 0);
    chk("rst_flags", flags, 0);
    chk("rst_irq", irq, 0);
    reset_n = 1'b1;
    chk("rel_flags", flags, 0);
    goto(100);
    chk("idle_flags", flags, 0);

    // Timer 0: preset 0xFE. It overflows on the 2nd base tick after start,
    // then every 2 base ticks.
    p = (102 / 4 + 1) * 4 + 4;
    for (int t = p; t <= 196; t += 8) exp_q0.push_back(t);
    exp_q0.push_back(204);      // last reload with 0xFE, then 0xFC takes over
    exp_q0.push_back(220);
    preset_at(101, 1'b0, 8'hFE);
    ctrl_at(102, 1'b0, 2'b00, 2'b01);
    goto(107);
    chk("t0_pre_flags", flags, 2'b00);
    goto(108);
    chk("t0_ovf_now", ovf_pulse, 2'b01);
    chk("t0_flags", flags, 2'b01);
    chk("t0_irq", irq, 1);
    goto(109);
    chk("t0_ovf_width", ovf_pulse, 2'b00);
    chk("t0_sticky", flags, 2'b01);

    // Timer 1: preset 0xFF overflows on every timer-1 tick. Rewriting
    // start0 1->1 must not reload timer 0.
    for (int t = 144; t <= 224; t += 16) exp_q1.push_back(t);
    preset_at(130, 1'b1, 8'hFF);
    ctrl_at(131, 1'b0, 2'b00, 2'b11);
    goto(145);
    chk("t1_flags", flags, 2'b11);

    // irq_rst coincides with a timer-0 overflow. The clear wins, and the
    // mask/start values in that write are ignored.
    ctrl_at(156, 1'b1, 2'b11, 2'b00);
    chk("irqrst_flags", flags, 2'b00);
    chk("irqrst_irq", irq, 0);
    goto(160);
    chk("irqrst_keep_t1", flags, 2'b10);
    goto(164);
    chk("irqrst_keep_mask", flags, 2'b11);

    // Masking: a mask write clears the flag, and masked overflows still pulse.
    ctrl_at(170, 1'b0, 2'b01, 2'b11);
    chk("mask0_clr", flags, 2'b10);
    goto(173);
    chk("mask0_noset", flags, 2'b10);
    ctrl_at(178, 1'b0, 2'b11, 2'b11);
    chk("mask1_clr", flags, 2'b00);
    chk("mask1_irq", irq, 0);
    goto(193);
    chk("masked_flags", flags, 2'b00);
    chk("masked_irq", irq, 0);

    // A preset write while running only affects the next reload.
    preset_at(197, 1'b0, 8'hFC);

    // Stop both timers, then restart. The restart reloads, and the
    // prescaler phase is unaffected.
    ctrl_at(226, 1'b0, 2'b11, 2'b00);
    exp_q0.push_back(256);
    exp_q1.push_back(256);
    ctrl_at(242, 1'b0, 2'b00, 2'b11);
    goto(257);
    chk("restart_flags", flags, 2'b11);
    chk("restart_irq", irq, 1);

    // Reset mid-count with counter0 = 0xFF.
    goto(270);
    chk("pre_rst_q0", exp_q0.size(), 0);
    chk("pre_rst_q1", exp_q1.size(), 0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ovf", ovf_pulse, 0);
    chk("mid_rst_flags", flags, 0);
    chk("mid_rst_irq", irq, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    goto(100);
    chk("post_rst_flags", flags, 0);

    // After reset, the counter and preset are 0, so a restart needs 256
    // ticks to overflow.
    exp_q0.push_back(104 + 255 * 4);
    ctrl_at(102, 1'b0, 2'b00, 2'b01);
    goto(1123);
    chk("zero_pre_flags", flags, 2'b00);
    goto(1130);
    chk("zero_flags", flags, 2'b01);
    chk("end_q0", exp_q0.size(), 0);
    chk("end_q1", exp_q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
